// File: rtl/axis_arb_pkg.sv
// Shared types for the round-robin packet arbiter: FSM encoding, source-index
// width helper and the skid-entry layout {tid, tlast, tdata}.
package axis_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_DRAIN = 2'd2
   } arb_state_e;

   // Source index width; never narrower than one bit.
   function automatic int src_w(input int num_src);
      return (num_src <= 2) ? 1 : $clog2(num_src);
   endfunction

   // Skid entry is packed as {tid, tlast, tdata}.
   function automatic int skid_entry_w(input int sw, input int dw);
      return sw + 1 + dw;
   endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer with registered outputs; in_ready depends only on the
// stored occupancy, so out_ready never reaches in_ready combinationally.
module axis_skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             full
);

   logic [1:0]       count_q;
   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] tail_q;
   logic             push;
   logic             pop;

   assign full      = (count_q == 2'd2);
   assign in_ready  = !full;
   assign out_valid = (count_q != 2'd0);
   assign out_data  = head_q;
   assign push      = in_valid && !full;
   assign pop       = out_valid && out_ready;

   // head_q is always the oldest entry; tail_q only holds the second one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 2'd0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         case (count_q)
            2'd0: begin
               if (push) begin
                  head_q  <= in_data;
                  count_q <= 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  head_q <= in_data;
               end else if (pop) begin
                  count_q <= 2'd0;
               end else if (push) begin
                  tail_q  <= in_data;
                  count_q <= 2'd2;
               end
            end
            default: begin
               if (pop) begin
                  head_q  <= tail_q;
                  count_q <= 2'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// Packet-granular round-robin arbiter: holds the grant from first beat to TLAST,
// truncates over-length packets and drains their remainder.
module axis_rr_packet_arbiter
   import axis_arb_pkg::*;
#(
   parameter  int NUM_SRC           = 4,
   parameter  int DATA_WIDTH        = 32,
   parameter  int STORAGE_IDX_WIDTH = 10,
   localparam int SRC_W             = src_w(NUM_SRC)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] S_AXI_TDATA,
   input  logic [NUM_SRC-1:0]            S_AXI_TVALID,
   output logic [NUM_SRC-1:0]            S_AXI_TREADY,
   input  logic [NUM_SRC-1:0]            S_AXI_TLAST,
   output logic [DATA_WIDTH-1:0]         M_AXI_TDATA,
   output logic                          M_AXI_TVALID,
   input  logic                          M_AXI_TREADY,
   output logic                          M_AXI_TLAST,
   output logic [SRC_W-1:0]              M_AXI_TID,
   input  logic                          enable,
   output logic                          busy,
   output logic                          pkt_done,
   output logic                          err_overlen,
   input  logic                          err_clr,
   output logic [1:0]                    state_dbg
);

   localparam int            EW        = skid_entry_w(SRC_W, DATA_WIDTH);
   localparam int            CW        = STORAGE_IDX_WIDTH;
   localparam logic [SRC_W:0] NUM_SRC_V = (SRC_W+1)'(NUM_SRC);

   arb_state_e           state_q, state_d;
   logic [SRC_W-1:0]     cur_src_q, cur_src_d;
   logic [SRC_W-1:0]     rr_last_q, rr_last_d;
   logic [CW-1:0]        beat_cnt_q, beat_cnt_d;
   logic                 pkt_done_q, pkt_done_d;
   logic                 err_q, err_set;

   logic [SRC_W:0]       start, sum;
   logic [2*NUM_SRC-1:0] dbl;
   logic [NUM_SRC-1:0]   rot;
   logic [SRC_W-1:0]     enc, pick_idx;
   logic                 pick_valid;

   logic                 sel_valid, sel_last, accept;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                 skid_full, skid_in_ready, push, push_last;
   logic [EW-1:0]        push_entry, skid_out;

   // Round-robin pick: rotate so rr_last+1 sits at bit 0, take the lowest set
   // bit, then rotate the index back.
   always_comb begin
      start = {1'b0, rr_last_q} + (SRC_W+1)'(1);
      if (start == NUM_SRC_V) start = '0;
      dbl = {S_AXI_TVALID, S_AXI_TVALID} >> start;
      rot = dbl[NUM_SRC-1:0];
      enc = '0;
      for (int i = NUM_SRC-1; i >= 0; i--) begin
         if (rot[i]) enc = SRC_W'(i);
      end
      sum = {1'b0, enc} + start;
      if (sum >= NUM_SRC_V) sum = sum - NUM_SRC_V;
      pick_idx   = sum[SRC_W-1:0];
      pick_valid = |S_AXI_TVALID;
   end

   assign sel_valid = S_AXI_TVALID[cur_src_q];
   assign sel_last  = S_AXI_TLAST[cur_src_q];
   assign sel_data  = S_AXI_TDATA[cur_src_q*DATA_WIDTH +: DATA_WIDTH];
   assign accept    = sel_valid && (((state_q == ST_GRANT) && !skid_full) ||
                                    (state_q == ST_DRAIN));

   always_comb begin
      S_AXI_TREADY = '0;
      if (state_q == ST_GRANT) S_AXI_TREADY[cur_src_q] = !skid_full;
      else if (state_q == ST_DRAIN) S_AXI_TREADY[cur_src_q] = 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      cur_src_d  = cur_src_q;
      rr_last_d  = rr_last_q;
      beat_cnt_d = beat_cnt_q;
      push       = 1'b0;
      push_last  = sel_last;
      pkt_done_d = 1'b0;
      err_set    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable && pick_valid) begin
               cur_src_d  = pick_idx;
               rr_last_d  = pick_idx;
               beat_cnt_d = '0;
               state_d    = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (accept) begin
               push = 1'b1;
               if (sel_last) begin
                  beat_cnt_d = beat_cnt_q + CW'(1);
                  pkt_done_d = 1'b1;
                  state_d    = ST_IDLE;
               end else if (&beat_cnt_q) begin
                  // Last storable beat: close the packet on M and discard the rest.
                  push_last  = 1'b1;
                  err_set    = 1'b1;
                  pkt_done_d = 1'b1;
                  state_d    = ST_DRAIN;
               end else begin
                  beat_cnt_d = beat_cnt_q + CW'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (accept && sel_last) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cur_src_q  <= '0;
         rr_last_q  <= SRC_W'(NUM_SRC-1);
         beat_cnt_q <= '0;
         pkt_done_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_src_q  <= cur_src_d;
         rr_last_q  <= rr_last_d;
         beat_cnt_q <= beat_cnt_d;
         pkt_done_q <= pkt_done_d;
         if (err_set) err_q <= 1'b1;
         else if (err_clr) err_q <= 1'b0;
      end
   end

   assign push_entry = {cur_src_q, push_last, sel_data};

   axis_skid_buffer #(.WIDTH(EW)) u_skid (
      .clk       (clk),
      .rst_n     (reset),
      .in_valid  (push),
      .in_ready  (skid_in_ready),
      .in_data   (push_entry),
      .out_valid (M_AXI_TVALID),
      .out_ready (M_AXI_TREADY),
      .out_data  (skid_out),
      .full      (skid_full)
   );

   assign {M_AXI_TID, M_AXI_TLAST, M_AXI_TDATA} = skid_out;
   assign busy        = (state_q != ST_IDLE) && skid_in_ready | (state_q != ST_IDLE);
   assign pkt_done    = pkt_done_q;
   assign err_overlen = err_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Directed bench for axis_rr_packet_arbiter: drivers push expected M beats into
// exp_q, a negedge monitor pops and compares. Truncation length here is 16 beats.
module tb_axis_rr_packet_arbiter;

   localparam int NS = 4;
   localparam int DW = 32;
   localparam int IW = 4;
   localparam int MAXLEN = 1 << IW;

   logic          clk = 1'b0;
   logic          reset;
   logic [NS*DW-1:0] S_AXI_TDATA;
   logic [NS-1:0] S_AXI_TVALID, S_AXI_TREADY, S_AXI_TLAST;
   logic [DW-1:0] M_AXI_TDATA;
   logic          M_AXI_TVALID, M_AXI_TREADY, M_AXI_TLAST;
   logic [1:0]    M_AXI_TID;
   logic          enable, busy, pkt_done, err_overlen, err_clr;
   logic [1:0]    state_dbg;

   logic [34:0]   exp_q[$];
   int            n_cmp = 0;
   int            n_fail = 0;
   int            pkt_done_cnt = 0;
   int            acc_cnt[NS];
   bit            abort = 0;
   bit            toggle_rdy = 0;
   bit            occ_track = 0;
   int            occ = 0;

   always #5 clk = ~clk;

   axis_rr_packet_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .STORAGE_IDX_WIDTH(IW)) dut (
      .clk(clk), .reset(reset),
      .S_AXI_TDATA(S_AXI_TDATA), .S_AXI_TVALID(S_AXI_TVALID),
      .S_AXI_TREADY(S_AXI_TREADY), .S_AXI_TLAST(S_AXI_TLAST),
      .M_AXI_TDATA(M_AXI_TDATA), .M_AXI_TVALID(M_AXI_TVALID),
      .M_AXI_TREADY(M_AXI_TREADY), .M_AXI_TLAST(M_AXI_TLAST), .M_AXI_TID(M_AXI_TID),
      .enable(enable), .busy(busy), .pkt_done(pkt_done),
      .err_overlen(err_overlen), .err_clr(err_clr), .state_dbg(state_dbg)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected M beats for one packet, including truncation at MAXLEN.
   task automatic exp_pkt(input int tid, input int n, input logic [31:0] base);
      for (int b = 0; b < n && b < MAXLEN; b++) begin
         logic [1:0] t;
         logic       l;
         t = 2'(tid);
         l = (b == n-1) || (b == MAXLEN-1);
         exp_q.push_back({t, l, base + 32'(b)});
      end
   endtask

   task automatic send_pkt(input int src, input int n, input logic [31:0] base);
      for (int b = 0; b < n && !abort; b++) begin
         bit rdy;
         int waits;
         rdy = 0;
         waits = 0;
         S_AXI_TVALID[src] = 1'b1;
         S_AXI_TDATA[src*DW +: DW] = base + 32'(b);
         S_AXI_TLAST[src] = (b == n-1);
         while (!rdy && !abort) begin
            @(negedge clk);
            rdy = S_AXI_TREADY[src];
            @(posedge clk);
            #1;
            if (!rdy) begin
               waits++;
               if (waits > 400) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL drv_timeout src%0d beat %0d: no ready in %0d cycles", src, b, waits);
                  b = n;
                  break;
               end
            end
         end
         if (rdy && !abort) acc_cnt[src]++;
      end
      S_AXI_TVALID[src] = 1'b0;
      S_AXI_TLAST[src] = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int i;
      i = 0;
      while ((exp_q.size() != 0 || busy) && i < 1000) begin
         @(posedge clk);
         #1;
         i++;
      end
      check(name, (i >= 1000), 0);
   endtask

   task automatic wait_acc(input int src, input int target);
      int i;
      i = 0;
      while (acc_cnt[src] < target && i < 1000) begin
         @(posedge clk);
         #2;
         i++;
      end
      check("wait_acc_timeout", (i >= 1000), 0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      M_AXI_TREADY = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (toggle_rdy) M_AXI_TREADY = ~M_AXI_TREADY;
         else M_AXI_TREADY = 1'b1;
      end
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (reset) begin
         check("s_tready_onehot0", $onehot0(S_AXI_TREADY), 1);
         if (occ_track) begin
            check("skid_valid_model", M_AXI_TVALID, (occ != 0));
            if (occ == 2) check("s_tready_when_full", S_AXI_TREADY[2], 0);
            occ = occ + int'(S_AXI_TVALID[2] && S_AXI_TREADY[2]) - int'(M_AXI_TVALID && M_AXI_TREADY);
         end
         if (M_AXI_TVALID && M_AXI_TREADY) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL sb_unexpected: got %0h expected no beat",
                        {M_AXI_TID, M_AXI_TLAST, M_AXI_TDATA});
            end else begin
               logic [34:0] e;
               e = exp_q.pop_front();
               check("sb_beat", {M_AXI_TID, M_AXI_TLAST, M_AXI_TDATA}, e);
            end
         end
         if (pkt_done) pkt_done_cnt++;
      end
   end

   initial begin
      int base;
      reset = 1'b0;
      enable = 1'b1;
      err_clr = 1'b0;
      S_AXI_TDATA = '0;
      S_AXI_TVALID = '0;
      S_AXI_TLAST = '0;
      for (int i = 0; i < NS; i++) acc_cnt[i] = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_tvalid", M_AXI_TVALID, 0);
      check("rst_m_fields", {M_AXI_TID, M_AXI_TLAST, M_AXI_TDATA}, 0);
      check("rst_s_tready", S_AXI_TREADY, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err_overlen, 0);
      check("rst_pkt_done", pkt_done, 0);
      check("rst_state", state_dbg, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // 1: single 3-beat packet, latency t+2
      pkt_done_cnt = 0;
      exp_pkt(0, 3, 32'hA0);
      fork
         send_pkt(0, 3, 32'hA0);
         begin
            @(posedge clk); @(negedge clk);
            check("t1_mvalid_t1", M_AXI_TVALID, 0);
            check("t1_busy_t1", busy, 1);
            for (int k = 0; k < 3; k++) begin
               @(posedge clk); @(negedge clk);
               check("t1_mvalid_stream", M_AXI_TVALID, 1);
            end
            @(posedge clk); @(negedge clk);
            check("t1_mvalid_after", M_AXI_TVALID, 0);
         end
      join
      wait_idle("t1_idle");
      check("t1_pkt_done", pkt_done_cnt, 1);

      // 2: all sources valid, grant order 0,1,2,3,0
      do_reset();
      pkt_done_cnt = 0;
      exp_pkt(0, 2, 32'hB0);
      exp_pkt(1, 2, 32'hC0);
      exp_pkt(2, 2, 32'hD0);
      exp_pkt(3, 2, 32'hE0);
      exp_pkt(0, 2, 32'hB8);
      fork
         begin
            send_pkt(0, 2, 32'hB0);
            send_pkt(0, 2, 32'hB8);
         end
         send_pkt(1, 2, 32'hC0);
         send_pkt(2, 2, 32'hD0);
         send_pkt(3, 2, 32'hE0);
      join
      wait_idle("t2_idle");
      check("t2_pkt_done", pkt_done_cnt, 5);

      // 3: 16-beat packet from src2 with M_TREADY toggling
      pkt_done_cnt = 0;
      occ = 0;
      occ_track = 1;
      toggle_rdy = 1;
      exp_pkt(2, 16, 32'h200);
      send_pkt(2, 16, 32'h200);
      wait_idle("t3_idle");
      occ_track = 0;
      toggle_rdy = 0;
      check("t3_pkt_done", pkt_done_cnt, 1);

      // 4: over-length packet truncated at 16 and drained
      check("t4_err_before", err_overlen, 0);
      pkt_done_cnt = 0;
      base = acc_cnt[1];
      exp_pkt(1, 20, 32'h100);
      send_pkt(1, 20, 32'h100);
      wait_idle("t4_idle");
      check("t4_drained_beats", acc_cnt[1] - base, 20);
      check("t4_err_set", err_overlen, 1);
      check("t4_pkt_done", pkt_done_cnt, 1);
      exp_pkt(0, 3, 32'h300);
      send_pkt(0, 3, 32'h300);
      wait_idle("t4_next_idle");
      check("t4_err_sticky", err_overlen, 1);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      check("t4_err_clr", err_overlen, 0);

      // 5: reset mid-packet, then src0 first
      pkt_done_cnt = 0;
      base = acc_cnt[0];
      exp_pkt(0, 6, 32'h400);
      fork
         send_pkt(0, 6, 32'h400);
         begin
            wait_acc(0, base + 3);
            @(negedge clk);
            #2;
            reset = 1'b0;
            abort = 1;
            S_AXI_TVALID = '0;
            exp_q.delete();
            #1;
            check("t5_async_mvalid", M_AXI_TVALID, 0);
            check("t5_async_busy", busy, 0);
            @(posedge clk);
            #1;
            check("t5_rst_m", {M_AXI_TVALID, M_AXI_TID, M_AXI_TLAST, M_AXI_TDATA}, 0);
            check("t5_rst_s_tready", S_AXI_TREADY, 0);
            check("t5_rst_pkt_done", pkt_done, 0);
            check("t5_rst_err", err_overlen, 0);
            check("t5_rst_state", state_dbg, 0);
         end
      join
      repeat (3) @(posedge clk);
      #1;
      check("t5_no_pkt_done", pkt_done_cnt, 0);
      abort = 0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      exp_pkt(0, 2, 32'h500);
      exp_pkt(2, 2, 32'h600);
      fork
         send_pkt(0, 2, 32'h500);
         send_pkt(2, 2, 32'h600);
      join
      wait_idle("t5_idle");

      // 6: enable low mid-packet
      pkt_done_cnt = 0;
      base = acc_cnt[3];
      exp_pkt(3, 4, 32'h700);
      exp_pkt(0, 2, 32'h800);
      exp_pkt(1, 2, 32'h900);
      fork
         send_pkt(3, 4, 32'h700);
         begin
            wait_acc(3, base + 1);
            enable = 1'b0;
            fork
               send_pkt(0, 2, 32'h800);
               send_pkt(1, 2, 32'h900);
            join
         end
         begin
            wait_acc(3, base + 4);
            repeat (2) @(posedge clk);
            for (int k = 0; k < 10; k++) begin
               @(negedge clk);
               check("t6_no_grant_busy", busy, 0);
               check("t6_no_grant_tready", S_AXI_TREADY, 0);
               check("t6_no_grant_mvalid", M_AXI_TVALID, 0);
            end
            @(posedge clk);
            #1;
            enable = 1'b1;
         end
      join
      wait_idle("t6_idle");
      check("t6_pkt_done", pkt_done_cnt, 3);

      repeat (3) @(posedge clk);
      check("final_queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, %0d compared %0d mismatched", n_cmp, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
